// File: rtl/pc_sequencer.sv
// pc_sequencer -- multi-cycle instruction address sequencer.
//
// Walks a step counter through 0..STEPS-1 once per instruction. The last
// step is the commit cycle: i_addr moves on to the next sequential address
// or to a branch target. Branch requests may arrive on any cycle (stalled
// or not) and are held in a single pending slot until the next commit; a
// newer request overwrites an older one.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to discard committed branch
// targets that are not multiples of INC (misalign_err pulses instead of
// redirect). Without it, targets are applied as given and misalign_err = 0.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   stall          in   freezes step and i_addr while high
//   branch_taken   in   one-cycle branch request
//   branch_target  in   redirect address, valid with branch_taken
//   i_addr         out  current instruction address
//   step           out  current step index 0..STEPS-1
//   can_write      out  commit cycle flag (combinational)
//   redirect       out  one-cycle pulse after a branch was applied
//   misalign_err   out  one-cycle pulse after a misaligned branch was dropped

module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                STEPS     = 5,
  parameter int                INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        step,
  output logic              can_write,
  output logic              redirect,
  output logic              misalign_err
);

  localparam logic [3:0]        LAST_STEP = 4'(STEPS - 1);
  localparam logic [ADDR_W-1:0] INC_V     = ADDR_W'(INC);

  logic [3:0]        step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              redirect_q, redirect_d;

  logic              commit;
  logic              use_branch;
  logic [ADDR_W-1:0] apply_tgt;
  logic              misaligned;

  // A request on the commit cycle itself outranks the pending slot.
  assign commit     = (step_q == LAST_STEP) && !stall;
  assign use_branch = branch_taken || pend_q;
  assign apply_tgt  = branch_taken ? branch_target : pend_tgt_q;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  logic misalign_q, misalign_d;

  assign misaligned = (apply_tgt & ALIGN_MASK) != '0;
  assign misalign_d = commit && use_branch && misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    step_d     = step_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    redirect_d = 1'b0;

    if (!stall) begin
      step_d = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
    end

    if (commit) begin
      // The pending slot is consumed by the commit even when the target is
      // dropped as misaligned, so a bad target never lingers.
      pend_d = 1'b0;
      if (use_branch && !misaligned) begin
        addr_d     = apply_tgt;
        redirect_d = 1'b1;
      end else begin
        addr_d = addr_q + INC_V;
      end
    end else if (branch_taken) begin
      pend_d     = 1'b1;
      pend_tgt_d = branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q     <= 4'd0;
      addr_q     <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      redirect_q <= 1'b0;
    end else begin
      step_q     <= step_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      redirect_q <= redirect_d;
    end
  end

  assign i_addr    = addr_q;
  assign step      = step_q;
  assign can_write = commit;
  assign redirect  = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer (default parameters, plus an 8-bit instance
// starting at 0xFC for address wrap). Reference model tracks instruction
// progress as plain integers and a pending-branch slot.

module tb_pc_sequencer;

  localparam int STEPS = 5;
  localparam int INC   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] i_addr;
  logic [3:0]  step;
  logic        can_write, redirect, misalign_err;

  logic        stall8 = 1'b0;
  logic        bt8 = 1'b0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  i_addr8;
  logic [3:0]  step8;
  logic        cw8, redir8, mis8;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .i_addr(i_addr), .step(step),
    .can_write(can_write), .redirect(redirect), .misalign_err(misalign_err)
  );

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'hFC)) dut8 (
    .clk(clk), .reset(reset), .stall(stall8), .branch_taken(bt8),
    .branch_target(tgt8), .i_addr(i_addr8), .step(step8),
    .can_write(cw8), .redirect(redir8), .misalign_err(mis8)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_step;
  logic [31:0] m_addr;
  logic [31:0] m_ptgt;
  bit          m_pend, m_redir, m_mis;

  task automatic model_reset();
    m_step = 0; m_addr = 32'h0; m_pend = 0; m_ptgt = '0; m_redir = 0; m_mis = 0;
  endtask

  task automatic drive(input bit st, input bit bt, input logic [31:0] tgt);
    stall = st; branch_taken = bt; branch_target = tgt;
    #1;
  endtask

  // Applies the current inputs to the model, then lets the DUT clock once.
  task automatic advance();
    bit          commit;
    logic [31:0] t;
    commit  = (m_step == STEPS - 1) && !stall;
    m_redir = 0;
    m_mis   = 0;
    if (commit) begin
      if (branch_taken || m_pend) begin
        t = branch_taken ? branch_target : m_ptgt;
`ifdef PC_MISALIGN_TRAP_EN
        if (t % INC != 0) begin
          m_addr = m_addr + 32'(INC);
          m_mis  = 1;
        end else begin
          m_addr  = t;
          m_redir = 1;
        end
`else
        m_addr  = t;
        m_redir = 1;
`endif
      end else begin
        m_addr = m_addr + 32'(INC);
      end
      m_pend = 0;
    end else if (branch_taken) begin
      m_pend = 1;
      m_ptgt = branch_target;
    end
    if (!stall) m_step = (m_step + 1) % STEPS;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (i_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h exp %h", i_addr, 32'h0); end
    n_cmp++; if (step !== 4'd0) begin n_err++; $display("FAIL reset_step: got %0d exp 0", step); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b exp 0", redirect); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b exp 0", misalign_err); end
    n_cmp++; if (can_write !== 1'b0) begin n_err++; $display("FAIL reset_can_write: got %b exp 0", can_write); end
    n_cmp++; if (i_addr8 !== 8'hFC) begin n_err++; $display("FAIL reset_addr8: got %h exp fc", i_addr8); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, '0);
      n_cmp++;
      if (can_write !== (c == 5 || c == 10)) begin
        n_err++; $display("FAIL seq_can_write c%0d: got %b exp %b", c, can_write, (c == 5 || c == 10));
      end
      advance();
      n_cmp++;
      if (i_addr !== 32'(4 * (c / 5))) begin
        n_err++; $display("FAIL seq_addr c%0d: got %h exp %h", c, i_addr, 32'(4 * (c / 5)));
      end
      n_cmp++;
      if (step !== 4'(c % 5)) begin n_err++; $display("FAIL seq_step c%0d: got %0d exp %0d", c, step, c % 5); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(0, 0, '0);        advance();   // step 0
    drive(0, 1, 32'h100);   advance();   // step 1
    drive(0, 0, '0);        advance();
    drive(0, 0, '0);        advance();
    drive(0, 0, '0);                     // step 4
    n_cmp++; if (can_write !== 1'b1) begin n_err++; $display("FAIL br_can_write: got %b exp 1", can_write); end
    advance();
    n_cmp++; if (i_addr !== 32'h100) begin n_err++; $display("FAIL br_addr: got %h exp 100", i_addr); end
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL br_redirect_hi: got %b exp 1", redirect); end
    drive(0, 0, '0); advance();
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL br_redirect_lo: got %b exp 0", redirect); end
    n_cmp++; if (i_addr !== 32'h100) begin n_err++; $display("FAIL br_addr_hold: got %h exp 100", i_addr); end
  endtask

  task automatic test_latest_wins();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 1)      drive(0, 1, 32'h200);
      else if (c == 4) drive(0, 1, 32'h300);
      else             drive(0, 0, '0);
      advance();
      if (redirect === 1'b1) pulses++;
      if (c == 4) begin
        n_cmp++; if (i_addr !== 32'h300) begin n_err++; $display("FAIL lw_addr: got %h exp 300", i_addr); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL lw_pulses: got %0d exp 1", pulses); end
    n_cmp++; if (i_addr !== 32'h304) begin n_err++; $display("FAIL lw_next_addr: got %h exp 304", i_addr); end
  endtask

  task automatic test_stall_branch();
    do_reset();
    for (int c = 0; c < 4; c++) begin drive(0, 0, '0); advance(); end
    for (int k = 0; k < 3; k++) begin
      drive(1, k == 0, 32'h40);
      n_cmp++; if (can_write !== 1'b0) begin n_err++; $display("FAIL st_can_write k%0d: got %b exp 0", k, can_write); end
      advance();
      n_cmp++; if (step !== 4'd4) begin n_err++; $display("FAIL st_step k%0d: got %0d exp 4", k, step); end
      n_cmp++; if (i_addr !== 32'h0) begin n_err++; $display("FAIL st_addr k%0d: got %h exp 0", k, i_addr); end
    end
    drive(0, 0, '0);
    n_cmp++; if (can_write !== 1'b1) begin n_err++; $display("FAIL st_release_cw: got %b exp 1", can_write); end
    advance();
    n_cmp++; if (i_addr !== 32'h40) begin n_err++; $display("FAIL st_release_addr: got %h exp 40", i_addr); end
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL st_release_redirect: got %b exp 1", redirect); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 4; c++) begin drive(0, 0, '0); advance(); end
    n_cmp++; if (i_addr8 !== 8'hFC) begin n_err++; $display("FAIL wrap_pre: got %h exp fc", i_addr8); end
    drive(0, 0, '0); advance();
    n_cmp++; if (i_addr8 !== 8'h00) begin n_err++; $display("FAIL wrap_addr: got %h exp 00", i_addr8); end
  endtask

  task automatic test_misalign();
    int mis_pulses = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(0, c == 1, 32'h10); advance(); end
    n_cmp++; if (i_addr !== 32'h10) begin n_err++; $display("FAIL mis_setup: got %h exp 10", i_addr); end
    for (int c = 0; c < 5; c++) begin
      drive(0, c == 1, 32'h102); advance();
      if (misalign_err === 1'b1) mis_pulses++;
    end
`ifdef PC_MISALIGN_TRAP_EN
    n_cmp++; if (i_addr !== 32'h14) begin n_err++; $display("FAIL mis_addr: got %h exp 14", i_addr); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b exp 1", misalign_err); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL mis_redirect: got %b exp 0", redirect); end
    drive(0, 0, '0); advance();
    if (misalign_err === 1'b1) mis_pulses++;
    n_cmp++; if (mis_pulses != 1) begin n_err++; $display("FAIL mis_pulses: got %0d exp 1", mis_pulses); end
`else
    n_cmp++; if (i_addr !== 32'h102) begin n_err++; $display("FAIL mis_addr: got %h exp 102", i_addr); end
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL mis_redirect: got %b exp 1", redirect); end
    n_cmp++; if (mis_pulses != 0) begin n_err++; $display("FAIL mis_pulses: got %0d exp 0", mis_pulses); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(0, 0, '0); advance(); end
    drive(0, 1, 32'h80); advance();      // step 0 -> pending
    drive(0, 0, '0);     advance();      // now at step 2
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (i_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %h exp 0", i_addr); end
    n_cmp++; if (step !== 4'd0) begin n_err++; $display("FAIL rm_step: got %0d exp 0", step); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rm_redirect: got %b exp 0", redirect); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin drive(0, 0, '0); advance(); end
    n_cmp++; if (i_addr !== 32'h4) begin n_err++; $display("FAIL rm_pending_dropped: got %h exp 4", i_addr); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rm_no_redirect: got %b exp 0", redirect); end
  endtask

  task automatic test_random();
    bit          st, bt, exp_cw;
    logic [31:0] tgt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom % 4) == 0;
      bt  = ($urandom % 6) == 0;
      tgt = $urandom;
      if (($urandom % 4) != 0) tgt = tgt & ~32'h3;
      drive(st, bt, tgt);
      exp_cw = (m_step == STEPS - 1) && !st;
      n_cmp++; if (can_write !== exp_cw) begin n_err++; $display("FAIL rnd_can_write c%0d: got %b exp %b", c, can_write, exp_cw); end
      advance();
      n_cmp++; if (i_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, i_addr, m_addr); end
      n_cmp++; if (step !== 4'(m_step)) begin n_err++; $display("FAIL rnd_step c%0d: got %0d exp %0d", c, step, m_step); end
      n_cmp++; if (redirect !== m_redir) begin n_err++; $display("FAIL rnd_redirect c%0d: got %b exp %b", c, redirect, m_redir); end
      n_cmp++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_misalign c%0d: got %b exp %b", c, misalign_err, m_mis); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_latest_wins();
    test_stall_branch();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the instruction address width.
REQ-002 Parameter STEPS, default 5, SHALL set the number of cycles per instruction, legal range 2..16.
REQ-003 Parameter INC, default 4, SHALL set the sequential address increment, a power of two.
REQ-004 Parameter RESET_VEC, default 0, SHALL set the address loaded on reset.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 stall  in  1  SHALL freeze step and address while high.
REQ-008 branch_taken  in  1  SHALL be a one-cycle branch/jump request.
REQ-009 branch_target  in  ADDR_W  SHALL give the redirect address, valid while branch_taken is high.
REQ-010 i_addr  out  ADDR_W  SHALL give the current instruction address.
REQ-011 step  out  4  SHALL give the current step index, 0..STEPS-1.
REQ-012 can_write  out  1  SHALL flag the commit cycle.
REQ-013 redirect  out  1  SHALL pulse for one cycle after a branch has been applied to i_addr.
REQ-014 misalign_err  out  1  SHALL pulse for one cycle after a misaligned branch has been discarded.

Function
REQ-015 step SHALL advance by 1 each cycle with stall low, and SHALL wrap from STEPS-1 to 0.
REQ-016 can_write SHALL be combinational: (step == STEPS-1) AND NOT stall.
REQ-017 On a commit cycle i_addr SHALL load the applied branch target if a branch is pending or presented that cycle, otherwise i_addr + INC, modulo 2^ADDR_W.
REQ-018 Outside commit cycles, and during any stall cycle, i_addr SHALL hold.
REQ-019 branch_taken SHALL be captured into a pending register (flag plus target) on any cycle, including stall cycles.
REQ-020 A later capture SHALL overwrite an earlier pending target (latest wins).
REQ-021 branch_taken on the commit cycle itself SHALL take priority over the pending register and SHALL be applied in that same commit.
REQ-022 The pending flag SHALL clear on the commit that consumes it.
REQ-023 A branch on a stalled commit cycle SHALL remain pending until the stall releases.
REQ-024 redirect SHALL be registered, high for exactly the one cycle after a commit that applied a branch.
REQ-025 Address arithmetic SHALL wrap silently at 2^ADDR_W with no flag.

Reset
REQ-026 reset low SHALL immediately force: i_addr = RESET_VEC, step = 0, pending flag = 0, redirect = 0, misalign_err = 0.
REQ-027 Reset asserted mid-instruction SHALL discard any pending branch.
REQ-028 After reset releases, the first commit SHALL occur STEPS cycles later, with i_addr = RESET_VEC + INC if no branch intervenes.

Configuration
REQ-029 Macro PC_MISALIGN_TRAP_EN SHALL control misaligned-branch checking.
REQ-030 With PC_MISALIGN_TRAP_EN defined, a committed branch SHALL be discarded if branch_target mod INC != 0; i_addr SHALL advance by INC, and misalign_err SHALL pulse one cycle later with redirect held low.
REQ-031 Without PC_MISALIGN_TRAP_EN, targets SHALL be applied unmodified and misalign_err SHALL be tied to 0.

Verification
REQ-032 Defaults; release reset; run 12 cycles -> can_write high on cycles 5 and 10; i_addr goes 0 -> 4 -> 8.
REQ-033 branch_taken with target 0x100 at step 1 -> next commit loads 0x100; redirect high for one cycle afterward.
REQ-034 Branches 0x200 at step 1 then 0x300 at step 4 (commit) -> i_addr = 0x300; a single redirect pulse.
REQ-035 stall held 3 cycles at step 4 with a branch to 0x40 -> step and i_addr frozen, can_write low; 0x40 loaded on the first unstalled cycle.
REQ-036 ADDR_W = 8, i_addr = 0xFC, no branch -> the commit wraps i_addr to 0x00.
REQ-037 PC_MISALIGN_TRAP_EN defined, branch to 0x102 from 0x10 -> i_addr = 0x14, misalign_err pulses once; reset low mid-step 2 -> i_addr = RESET_VEC immediately.
